// File: rtl/fft_reorder_256.sv
// rtl/fft_reorder_256.sv - ping-pong reorder buffer, bit-reversed FFT output to natural order
//
// Stores each 256-sample frame arriving in bit-reversed order into one of two
// banks, then replays the completed bank in natural order X[0]..X[255].
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   Data_in_r/i, in_valid    input sample (bit-reversed order), accepted when in_valid
//   in_sop                   frame-start realign marker (qualified by in_valid)
//   Data_out_r/i, out_valid  natural-order output sample
//   out_sop, out_eop         high with X[0] / X[255]
//   err_sync                 one-cycle pulse when a partial frame is discarded
module fft_reorder_256 #(
  parameter int DW   = 16,
  parameter int N    = 256,
  parameter int LOGN = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] Data_in_r,
  input  logic [DW-1:0] Data_in_i,
  input  logic          in_valid,
  input  logic          in_sop,
  output logic [DW-1:0] Data_out_r,
  output logic [DW-1:0] Data_out_i,
  output logic          out_valid,
  output logic          out_sop,
  output logic          out_eop,
  output logic          err_sync
);

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  // Bank select is the top address bit.
  logic [2*DW-1:0] mem [0:2*N-1];
  logic [2*DW-1:0] rd_data_q;

  logic [LOGN-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            rd_active_q, rd_active_d;

  // Stage 1 tracks the RAM read, stage 2 is the output register.
  logic            v1_q, sop1_q, eop1_q;
  logic [DW-1:0]   out_r_q, out_i_q;
  logic            out_valid_q, out_sop_q, out_eop_q, err_q;

  logic            realign;
  logic            frame_done;
  logic [LOGN-1:0] wr_addr;

  always_comb begin
    realign     = in_valid && in_sop && (wr_cnt_q != '0);
    // A realign on the last slot restarts the frame instead of completing it.
    frame_done  = in_valid && !realign && (wr_cnt_q == '1);
    wr_addr     = realign ? '0 : wr_cnt_q;

    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    rd_active_d = rd_active_q;

    if (in_valid) begin
      wr_cnt_d = realign ? LOGN'(1) : wr_cnt_q + LOGN'(1);
    end

    if (frame_done) begin
      // Handing over a new bank also covers the back-to-back case where the
      // previous replay is on its last sample this same edge.
      wr_bank_d   = ~wr_bank_q;
      rd_bank_d   = wr_bank_q;
      rd_active_d = 1'b1;
      rd_cnt_d    = '0;
    end else if (rd_active_q) begin
      rd_cnt_d = rd_cnt_q + LOGN'(1);
      if (rd_cnt_q == '1) rd_active_d = 1'b0;
    end
  end

  // Storage is never cleared; only the control path is reset.
  always_ff @(posedge CLK) begin
    if (in_valid) mem[{wr_bank_q, wr_addr}] <= {Data_in_r, Data_in_i};
    rd_data_q <= mem[{rd_bank_q, bitrev(rd_cnt_q)}];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_active_q <= 1'b0;
      v1_q        <= 1'b0;
      sop1_q      <= 1'b0;
      eop1_q      <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_active_q <= rd_active_d;
      v1_q        <= rd_active_q;
      sop1_q      <= rd_active_q && (rd_cnt_q == '0);
      eop1_q      <= rd_active_q && (rd_cnt_q == '1);
      if (v1_q) begin
        out_r_q <= rd_data_q[2*DW-1:DW];
        out_i_q <= rd_data_q[DW-1:0];
      end
      out_valid_q <= v1_q;
      out_sop_q   <= sop1_q;
      out_eop_q   <= eop1_q;
      err_q       <= realign;
    end
  end

  assign Data_out_r = out_r_q;
  assign Data_out_i = out_i_q;
  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign err_sync   = err_q;

endmodule

// File: tb/tb_fft_reorder_256.sv
// tb/tb_fft_reorder_256.sv - self-checking bench for fft_reorder_256
module tb_fft_reorder_256;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] Data_in_r = '0;
  logic [DW-1:0] Data_in_i = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic [DW-1:0] Data_out_r, Data_out_i;
  logic          out_valid, out_sop, out_eop, err_sync;

  always #5 CLK = ~CLK;

  fft_reorder_256 #(.DW(DW), .N(256), .LOGN(8)) dut (
    .CLK(CLK), .RST(RST),
    .Data_in_r(Data_in_r), .Data_in_i(Data_in_i),
    .in_valid(in_valid), .in_sop(in_sop),
    .Data_out_r(Data_out_r), .Data_out_i(Data_out_i),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .err_sync(err_sync)
  );

  typedef struct {
    int          cyc;
    logic [31:0] d;
    bit          sop;
    bit          eop;
  } exp_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] frame_q[$];
  exp_t        exp_q[$];
  bit          exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int brev8(input int a);
    int r = 0;
    for (int i = 0; i < 8; i++) r = r * 2 + ((a >> i) & 1);
    return r;
  endfunction

  // Reference: collect a frame in arrival order; once 256 samples are in,
  // schedule natural-order output k = arrival[bitrev(k)] at completion edge + 2 + k.
  task automatic step(input bit rst, input bit v, input bit s,
                      input logic [15:0] re, input logic [15:0] im);
    int   e;
    exp_t x;
    RST       = rst;
    in_valid  = v;
    in_sop    = s;
    Data_in_r = re;
    Data_in_i = im;
    e         = cyc + 1;
    exp_err   = 1'b0;
    if (rst) begin
      frame_q.delete();
      exp_q.delete();
    end else if (v) begin
      if (s && frame_q.size() != 0) begin
        frame_q.delete();
        exp_err = 1'b1;
      end
      frame_q.push_back({re, im});
      if (frame_q.size() == 256) begin
        for (int k = 0; k < 256; k++) begin
          x.cyc = e + 2 + k;
          x.d   = frame_q[brev8(k)];
          x.sop = (k == 0);
          x.eop = (k == 255);
          exp_q.push_back(x);
        end
        frame_q.delete();
      end
    end
    @(posedge CLK);
    cyc++;
    #1;
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      chk("out_valid", {31'b0, out_valid}, 32'd1);
      chk("data", {Data_out_r, Data_out_i}, exp_q[0].d);
      chk("out_sop", {31'b0, out_sop}, {31'b0, exp_q[0].sop});
      chk("out_eop", {31'b0, out_eop}, {31'b0, exp_q[0].eop});
      void'(exp_q.pop_front());
    end else begin
      chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
    end
    chk("err_sync", {31'b0, err_sync}, {31'b0, exp_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] r16, i16;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rst_data_r", {16'b0, Data_out_r}, 32'd0);
    chk("rst_data_i", {16'b0, Data_out_i}, 32'd0);
    chk("rst_sop", {31'b0, out_sop}, 32'd0);
    chk("rst_eop", {31'b0, out_eop}, 32'd0);
    idle(3);

    // Single continuous frame, sample j = (j, -j)
    for (int j = 0; j < 256; j++) step(1'b0, 1'b1, j == 0, 16'(j), 16'(0 - j));
    idle(260);

    // Three back-to-back frames
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 256; j++) begin
        i16 = 16'($urandom);
        step(1'b0, 1'b1, j == 0, 16'(1000 * f + j), i16);
      end
    idle(260);

    // Gapped input: valid on every third cycle
    for (int j = 0; j < 256; j++) begin
      step(1'b0, 1'b1, 1'b0, 16'(j), 16'(0 - j));
      idle(2);
    end
    idle(260);

    // Realign at j = 100 then a clean frame
    for (int j = 0; j < 100; j++) step(1'b0, 1'b1, j == 0, 16'(16'h8000 + j), 16'h0bad);
    for (int j = 0; j < 256; j++) step(1'b0, 1'b1, j == 0, 16'(j), 16'(3 * j));
    idle(260);

    // Reset at output index 50, then a new frame
    for (int j = 0; j < 256; j++) step(1'b0, 1'b1, 1'b0, 16'(j + 7), 16'(j));
    idle(51);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int j = 0; j < 256; j++) begin
      r16 = 16'($urandom);
      i16 = 16'($urandom);
      step(1'b0, 1'b1, 1'b0, r16, i16);
    end
    idle(260);

    // Reset during filling at j = 200, then fresh samples
    for (int j = 0; j < 200; j++) step(1'b0, 1'b1, 1'b0, 16'hdead, 16'(j));
    step(1'b1, 1'b1, 1'b0, 16'hdead, 16'hdead);
    for (int j = 0; j < 256; j++) step(1'b0, 1'b1, 1'b0, 16'(j), 16'(255 - j));
    idle(260);

    // Random valid density, stray sop markers, rare resets
    for (int i = 0; i < 2000; i++) begin
      r16 = 16'($urandom);
      i16 = 16'($urandom);
      step($urandom_range(0, 999) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 299) == 0, r16, i16);
    end
    idle(260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
